team_06_delay_mem_ctrl: RTL

Sequencer for the echo/reverb delay line: on each audio sample tick it reads the delayed sample from the shared SRAM, presents it to the echo/reverb datapath, and writes the datapath's save value back into a circular buffer. Sits between the sample-rate timing source, the echo/reverb datapath and the SRAM port. It owns the buffer write pointer, the read-address arithmetic and the warm-up tracking.

---
 rtl/team_06_pkg.sv | 15 +
 rtl/team_06_delay_mem_ctrl_if.sv | 26 ++
 rtl/team_06_ring_ptr.sv | 41 ++++
 rtl/team_06_delay_mem_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/team_06_pkg.sv
// Shared types and defaults for the echo/reverb delay-line sequencer.
package team_06_pkg;

  localparam int DELAY_DEFAULT = 8000;
  localparam int DLY_ADDR_W    = 13;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    CALC,
    WR_REQ,
    DONE
  } delay_state_t;

endpackage

// File: rtl/team_06_delay_mem_ctrl_if.sv
// SRAM request/ack port between the delay-line sequencer (master) and the shared SRAM (slave).
interface team_06_delay_mem_ctrl_if
  import team_06_pkg::*;
#(
  parameter int ADDR_W = DLY_ADDR_W,
  parameter int DATA_W = 8
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/team_06_ring_ptr.sv
// Circular-buffer write pointer, warm-up fill counter and delayed read address.
// The fill counter saturates at DELAY; once it gets there, the read slot holds real history.
module team_06_ring_ptr
  import team_06_pkg::*;
#(
  parameter int ADDR_W = DLY_ADDR_W,
  parameter int DELAY  = DELAY_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              advance,
  input  logic              clear_fill,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              full
);

  localparam logic [ADDR_W-1:0] DLY = ADDR_W'(DELAY);

  logic [ADDR_W-1:0] fill_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      if (advance) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (clear_fill) begin
        fill_cnt <= '0;
      end else if (advance && (fill_cnt != DLY)) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  assign rd_addr = wr_ptr - DLY;
  assign full    = (fill_cnt == DLY);

endmodule

// File: rtl/team_06_delay_mem_ctrl.sv
// Per-sample sequencer: read the delayed sample, give the datapath a cycle, write its save value back.
// Zero-wait latency is tick + 4 cycles. Ticks that arrive while busy are dropped and flagged as overrun.
module team_06_delay_mem_ctrl
  import team_06_pkg::*;
#(
  parameter int ADDR_W = DLY_ADDR_W,
  parameter int DATA_W = 8,
  parameter int DELAY  = DELAY_DEFAULT
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         sample_tick,
  input  logic [DATA_W-1:0]            audio_in,
  input  logic                         echo_en,
  input  logic                         reverb_en,
  output logic [DATA_W-1:0]            dp_audio,
  output logic [DATA_W-1:0]            dp_past,
  input  logic [DATA_W-1:0]            dp_save,
  team_06_delay_mem_ctrl_if.master     mem,
  output logic                         busy,
  output logic                         sample_done,
  output logic                         overrun
);

  delay_state_t      state_q, state_d;
  logic              valid_mode;
  logic              advance;
  logic              clear_fill;
  logic              full;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wdata_q;

  assign valid_mode = echo_en ^ reverb_en;
  assign advance    = (state_q == WR_REQ) && mem.mem_ack;
  assign clear_fill = (state_q == IDLE) && sample_tick && !valid_mode;

  team_06_ring_ptr #(
    .ADDR_W (ADDR_W),
    .DELAY  (DELAY)
  ) u_ring_ptr (
    .clk        (clk),
    .n_rst      (n_rst),
    .advance    (advance),
    .clear_fill (clear_fill),
    .wr_ptr     (wr_ptr),
    .rd_addr    (rd_addr),
    .full       (full)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = valid_mode ? RD_REQ : DONE;
      RD_REQ:  if (mem.mem_ack) state_d = CALC;
      CALC:    state_d = WR_REQ;
      WR_REQ:  if (mem.mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy and sample_done are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_audio    <= '0;
      dp_past     <= '0;
      wdata_q     <= '0;
      busy        <= 1'b0;
      sample_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if ((state_q == IDLE) && sample_tick) begin
        dp_audio <= audio_in;
      end
      if ((state_q == RD_REQ) && mem.mem_ack) begin
        dp_past <= full ? mem.mem_rdata : '0;
      end
      if (state_q == CALC) begin
        wdata_q <= dp_save;
      end
      busy        <= (state_d != IDLE);
      sample_done <= (state_d == DONE);
      if (sample_tick && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = '0;
    case (state_q)
      RD_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = rd_addr;
      end
      WR_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = wr_ptr;
      end
      default: ;
    endcase
  end

  assign mem.mem_wdata = wdata_q;

endmodule
